// File: rtl/vrased_reset_seq_if.sv
// rtl/vrased_reset_seq_if.sv - wipe write port between reset sequencer and secure stack memory
interface vrased_reset_seq_if;
  logic        wipe_en;
  logic [15:0] wipe_addr;
  logic [15:0] wipe_data;
  logic        wipe_ack;

  modport master (output wipe_en, output wipe_addr, output wipe_data, input wipe_ack);
  modport slave  (input wipe_en, input wipe_addr, input wipe_data, output wipe_ack);
endinterface

// File: rtl/vrased_reset_seq.sv
// rtl/vrased_reset_seq.sv - VRASED violation reset sequencer: hold, stack zeroize, release
module vrased_reset_seq #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [15:0] SCRUB_BASE  = 16'h0A00,
  parameter int unsigned SCRUB_WORDS = 128,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             viol_req,
  input  logic [5:0]       viol_src,
  input  logic             cause_clr,
  vrased_reset_seq_if.master wipe,
  output logic             puc_rst,
  output logic             busy,
  output logic [5:0]       cause,
  output logic [CNT_W-1:0] viol_cnt
);

  typedef enum logic [1:0] {IDLE, HOLD, SCRUB, RELEASE} state_t;

  localparam logic [15:0]      HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]      LAST_IDX  = 16'(SCRUB_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t      state;
  logic [15:0] hold_cnt;
  logic [15:0] idx;
  logic        start;

  // A request only starts a new event from IDLE or RELEASE; in HOLD/SCRUB it just adds cause bits.
  assign start = viol_req && (state == IDLE || state == RELEASE);

  assign wipe.wipe_data = 16'h0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      puc_rst        <= 1'b0;
      busy           <= 1'b0;
      wipe.wipe_en   <= 1'b0;
      wipe.wipe_addr <= SCRUB_BASE;
      cause          <= 6'd0;
      viol_cnt       <= '0;
      hold_cnt       <= 16'd0;
      idx            <= 16'd0;
    end else if (start) begin
      state          <= HOLD;
      puc_rst        <= 1'b1;
      busy           <= 1'b1;
      wipe.wipe_en   <= 1'b0;
      wipe.wipe_addr <= SCRUB_BASE;
      hold_cnt       <= HOLD_LOAD;
      idx            <= 16'd0;
      cause          <= (state == IDLE && cause_clr) ? viol_src : (cause | viol_src);
      if (viol_cnt != CNT_MAX) viol_cnt <= viol_cnt + 1'b1;
    end else begin
      if (viol_req) cause <= cause | viol_src;
      case (state)
        IDLE: begin
          if (cause_clr) cause <= 6'd0;
        end
        HOLD: begin
          if (hold_cnt == 16'd0) begin
            if (SCRUB_WORDS == 0) begin
              state   <= RELEASE;
              puc_rst <= 1'b0;
            end else begin
              state        <= SCRUB;
              wipe.wipe_en <= 1'b1;
              idx          <= 16'd0;
            end
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        SCRUB: begin
          if (wipe.wipe_ack) begin
            wipe.wipe_addr <= wipe.wipe_addr + 16'd2;
            idx            <= idx + 16'd1;
            if (idx == LAST_IDX) begin
              state        <= RELEASE;
              wipe.wipe_en <= 1'b0;
              puc_rst      <= 1'b0;
            end
          end
        end
        RELEASE: begin
          state          <= IDLE;
          busy           <= 1'b0;
          wipe.wipe_addr <= SCRUB_BASE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vrased_reset_seq.sv
// tb/tb_vrased_reset_seq.sv - directed table-driven bench for vrased_reset_seq
module tb_vrased_reset_seq;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       viol_req = 1'b0;
  logic [5:0] viol_src = 6'd0;
  logic       cause_clr = 1'b0;

  logic       puc_a, busy_a, puc_b, busy_b;
  logic [5:0] cause_a, cause_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  int checks = 0;
  int errors = 0;

  vrased_reset_seq_if wa ();
  vrased_reset_seq_if wb ();

  always #5 clk = ~clk;

  vrased_reset_seq #(.HOLD_CYCLES(4), .SCRUB_BASE(16'h0A00), .SCRUB_WORDS(3), .CNT_W(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .viol_req(viol_req), .viol_src(viol_src), .cause_clr(cause_clr),
    .wipe(wa.master), .puc_rst(puc_a), .busy(busy_a), .cause(cause_a), .viol_cnt(cnt_a));

  vrased_reset_seq #(.HOLD_CYCLES(4), .SCRUB_BASE(16'h0A00), .SCRUB_WORDS(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .viol_req(viol_req), .viol_src(viol_src), .cause_clr(cause_clr),
    .wipe(wb.master), .puc_rst(puc_b), .busy(busy_b), .cause(cause_b), .viol_cnt(cnt_b));

  assign wb.wipe_ack = 1'b1;

  typedef struct {
    logic        req;
    logic [5:0]  src;
    logic        ack;
    logic        clr;
    logic        puc;
    logic        en;
    logic [15:0] addr;
    logic        busy;
    logic [5:0]  cause;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic req, logic [5:0] src, logic ack, logic clr, logic puc, logic en,
                             logic [15:0] addr, logic busy, logic [5:0] cause, logic [1:0] cnt);
    vec_t r;
    r.req = req; r.src = src; r.ack = ack; r.clr = clr; r.puc = puc; r.en = en;
    r.addr = addr; r.busy = busy; r.cause = cause; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_a(string tag, logic puc, logic en, logic [15:0] addr, logic busy,
                       logic [5:0] cause, logic [1:0] cnt);
    chk({tag, " puc_rst"}, 32'(puc_a), 32'(puc));
    chk({tag, " wipe_en"}, 32'(wa.wipe_en), 32'(en));
    chk({tag, " wipe_addr"}, 32'(wa.wipe_addr), 32'(addr));
    chk({tag, " busy"}, 32'(busy_a), 32'(busy));
    chk({tag, " cause"}, 32'(cause_a), 32'(cause));
    chk({tag, " viol_cnt"}, 32'(cnt_a), 32'(cnt));
    chk({tag, " wipe_data"}, 32'(wa.wipe_data), 32'h0);
  endtask

  // The zero-word instance must never issue a wipe write.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (wb.wipe_en !== 1'b0) begin
        errors++;
        $display("FAIL b_wipe_en_idle: got %0b expected 0", wb.wipe_en);
      end
    end
  end

  initial begin
    wa.wipe_ack = 1'b1;

    // scrub of 3 words with ack tied high
    tbl.push_back(v(1, 6'h01, 1, 0, 1, 0, 16'h0A00, 1, 6'h01, 2'd1));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 6'h00, 1, 0, 1, 0, 16'h0A00, 1, 6'h01, 2'd1));
    tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A00, 1, 6'h01, 2'd1));
    tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A02, 1, 6'h01, 2'd1));
    tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A04, 1, 6'h01, 2'd1));
    tbl.push_back(v(0, 6'h00, 1, 0, 0, 0, 16'h0A06, 1, 6'h01, 2'd1));
    tbl.push_back(v(0, 6'h00, 1, 0, 0, 0, 16'h0A00, 0, 6'h01, 2'd1));
    // stalled ack on word 1, requests and clear during the sequence
    tbl.push_back(v(1, 6'h01, 1, 0, 1, 0, 16'h0A00, 1, 6'h01, 2'd2));
    tbl.push_back(v(0, 6'h00, 1, 0, 1, 0, 16'h0A00, 1, 6'h01, 2'd2));
    tbl.push_back(v(1, 6'h02, 1, 0, 1, 0, 16'h0A00, 1, 6'h03, 2'd2));
    tbl.push_back(v(0, 6'h00, 1, 0, 1, 0, 16'h0A00, 1, 6'h03, 2'd2));
    tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A00, 1, 6'h03, 2'd2));
    tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A02, 1, 6'h03, 2'd2));
    tbl.push_back(v(1, 6'h10, 0, 0, 1, 1, 16'h0A02, 1, 6'h13, 2'd2));
    tbl.push_back(v(0, 6'h00, 0, 1, 1, 1, 16'h0A02, 1, 6'h13, 2'd2));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 6'h00, 0, 0, 1, 1, 16'h0A02, 1, 6'h13, 2'd2));
    tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A04, 1, 6'h13, 2'd2));
    tbl.push_back(v(0, 6'h00, 1, 0, 0, 0, 16'h0A06, 1, 6'h13, 2'd2));
    // request in RELEASE re-enters HOLD, then saturation with a zero-source event
    for (int e = 0; e < 2; e++) begin
      logic [5:0] s;
      s = (e == 0) ? 6'h04 : 6'h00;
      tbl.push_back(v(1, s, 1, 0, 1, 0, 16'h0A00, 1, 6'h17, 2'd3));
      for (int k = 0; k < 3; k++) tbl.push_back(v(0, 6'h00, 1, 0, 1, 0, 16'h0A00, 1, 6'h17, 2'd3));
      tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A00, 1, 6'h17, 2'd3));
      tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A02, 1, 6'h17, 2'd3));
      tbl.push_back(v(0, 6'h00, 1, 0, 1, 1, 16'h0A04, 1, 6'h17, 2'd3));
      tbl.push_back(v(0, 6'h00, 1, 0, 0, 0, 16'h0A06, 1, 6'h17, 2'd3));
      if (e == 1) tbl.push_back(v(0, 6'h00, 1, 0, 0, 0, 16'h0A00, 0, 6'h17, 2'd3));
    end
    // clear in IDLE, then clear together with a new event
    tbl.push_back(v(0, 6'h00, 1, 1, 0, 0, 16'h0A00, 0, 6'h00, 2'd3));
    tbl.push_back(v(1, 6'h20, 1, 1, 1, 0, 16'h0A00, 1, 6'h20, 2'd3));

    repeat (2) @(negedge clk);
    chk_a("reset_held", 0, 0, 16'h0A00, 0, 6'h00, 2'd0);
    reset_n = 1'b1;
    step();
    chk_a("after_reset", 0, 0, 16'h0A00, 0, 6'h00, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      viol_req    = tbl[i].req;
      viol_src    = tbl[i].src;
      wa.wipe_ack = tbl[i].ack;
      cause_clr   = tbl[i].clr;
      step();
      chk_a($sformatf("row%0d", i), tbl[i].puc, tbl[i].en, tbl[i].addr, tbl[i].busy,
            tbl[i].cause, tbl[i].cnt);
    end

    // asynchronous reset in the middle of a scrub
    viol_req = 1'b0; viol_src = 6'd0; cause_clr = 1'b0; wa.wipe_ack = 1'b1;
    repeat (4) step();
    chk_a("pre_abort_scrub", 1, 1, 16'h0A00, 1, 6'h20, 2'd3);
    step();
    chk_a("pre_abort_word1", 1, 1, 16'h0A02, 1, 6'h20, 2'd3);
    wa.wipe_ack = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_a("async_abort", 0, 0, 16'h0A00, 0, 6'h00, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wa.wipe_ack = 1'b1;
    viol_req = 1'b1; viol_src = 6'h2A; cause_clr = 1'b1;
    step();
    chk_a("post_abort_evt", 1, 0, 16'h0A00, 1, 6'h2A, 2'd1);
    viol_req = 1'b0; viol_src = 6'd0; cause_clr = 1'b0;

    // zero-word instance goes straight from HOLD to RELEASE
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    viol_req = 1'b1; viol_src = 6'h08;
    step();
    viol_req = 1'b0; viol_src = 6'd0;
    chk("b_evt puc_rst", 32'(puc_b), 32'h1);
    chk("b_evt busy", 32'(busy_b), 32'h1);
    chk("b_evt viol_cnt", 32'(cnt_b), 32'h1);
    chk("b_evt cause", 32'(cause_b), 32'h08);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("b_seq%0d puc_rst", k), 32'(puc_b), (k < 3) ? 32'h1 : 32'h0);
      chk($sformatf("b_seq%0d busy", k), 32'(busy_b), (k < 4) ? 32'h1 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
